// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg: op and state encodings plus a width helper shared by the serial ALU path.
package serial_alu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SLT = 2'b10;

    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_DONE = 2'b10} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r = r + 1;
        return r;
    endfunction
endpackage

// File: rtl/serial_add_sub_bit.sv
// serial_add_sub_bit: 1-bit full-adder slice; overflow is meaningful only on the MSB slice.
module serial_add_sub_bit (
    input  logic a,
    input  logic b,
    input  logic carryin,
    output logic sum,
    output logic carryout,
    output logic overflow
);
    assign sum      = a ^ b ^ carryin;
    assign carryout = (a & b) | (a & carryin) | (b & carryin);
    assign overflow = carryin ^ carryout;
endmodule

// File: rtl/serial_add_sub_ctrl.sv
// serial_add_sub_ctrl: bit-serial WIDTH-bit add/sub through one slice, LSB first.
// Optional SERIAL_SLT_EN turns op 2'b10 into set-less-than.
module serial_add_sub_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);
    localparam int CW = clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sa, sb, res_n, res_last;
    logic [CW-1:0]    cnt;
    logic             carry, sum, cout, ovf, sub, accept, last;

    serial_add_sub_bit u_bit (
        .a        (sa[0]),
        .b        (sb[0]),
        .carryin  (carry),
        .sum      (sum),
        .carryout (cout),
        .overflow (ovf)
    );

    assign accept = start && state != ST_RUN;
    assign last   = cnt == CW'(WIDTH - 1);
    assign res_n  = {sum, result[WIDTH-1:1]};

`ifdef SERIAL_SLT_EN
    logic slt;
    assign sub      = op == OP_SUB || op == OP_SLT;
    // true sign of a-b is the raw sign corrected by overflow
    assign res_last = slt ? {{(WIDTH-1){1'b0}}, sum ^ ovf} : res_n;
    always_ff @(posedge clk or posedge reset)
        if (reset) slt <= 1'b0;
        else if (accept) slt <= op == OP_SLT;
`else
    assign sub      = op == OP_SUB;
    assign res_last = res_n;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            sa       <= '0;
            sb       <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            carryout <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state  <= ST_RUN;
                busy   <= 1'b1;
                sa     <= a;
                sb     <= sub ? ~b : b;
                carry  <= sub;
                cnt    <= '0;
                result <= '0;
            end else if (state == ST_RUN) begin
                sa     <= sa >> 1;
                sb     <= sb >> 1;
                carry  <= cout;
                cnt    <= cnt + 1'b1;
                result <= res_n;
                if (last) begin
                    state    <= ST_DONE;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    result   <= res_last;
                    carryout <= cout;
                    overflow <= ovf;
                    zero     <= res_last == '0;
                end
            end else begin
                state <= ST_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_serial_add_sub_ctrl.sv
// tb_serial_add_sub_ctrl: directed scoreboard bench for WIDTH=4 and WIDTH=32 instances.
module tb_serial_add_sub_ctrl;
    typedef struct packed {
        logic [63:0] r;
        logic        c;
        logic        v;
        logic        z;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1;
    logic        start4 = 1'b0, start32 = 1'b0;
    logic [1:0]  op4 = 2'b00, op32 = 2'b00;
    logic [3:0]  a4 = '0, b4 = '0, res4;
    logic [31:0] a32 = '0, b32 = '0, res32;
    logic        busy4, done4, co4, ov4, z4;
    logic        busy32, done32, co32, ov32, z32;
    int          pass_cnt = 0, total = 0;
    exp_t        q4[$], q32[$];

    always #5 clk = ~clk;

    serial_add_sub_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .op(op4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .result(res4), .carryout(co4), .overflow(ov4), .zero(z4)
    );

    serial_add_sub_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(res32), .carryout(co32), .overflow(ov32), .zero(z32)
    );

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) pass_cnt++;
        else $error("FAIL %s: got %0h expected %0h", tag, o, e);
    endtask

    function automatic exp_t model(input int w, input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        exp_t        e;
        logic [64:0] mask, xx, yy, s, r;
        logic        sub, slt;
        slt  = 1'b0;
`ifdef SERIAL_SLT_EN
        slt  = o == 2'b10;
`endif
        sub  = o == 2'b01 || slt;
        mask = (65'd1 << w) - 65'd1;
        xx   = {1'b0, x} & mask;
        yy   = {1'b0, sub ? ~y : y} & mask;
        s    = xx + yy + {64'd0, sub};
        r    = s & mask;
        e.c  = s[w];
        e.v  = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
        if (slt) r = {64'd0, r[w-1] ^ e.v};
        e.z  = r == '0;
        e.r  = r[63:0];
        return e;
    endfunction

    task automatic go4(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        op4 = o; a4 = x; b4 = y; start4 = 1'b1;
        q4.push_back(model(4, o, {60'd0, x}, {60'd0, y}));
        @(negedge clk);
        start4 = 1'b0; a4 = ~x; b4 = ~y;
    endtask

    task automatic wait4(input int lat);
        int   n;
        exp_t e;
        n = 0;
        while (!done4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("timeout4", {63'd0, done4}, 64'd1);
        if (done4 && q4.size() > 0) begin
            e = q4.pop_front();
            chk("lat4", n, lat);
            chk("res4", {60'd0, res4}, e.r);
            chk("co4", {63'd0, co4}, {63'd0, e.c});
            chk("ov4", {63'd0, ov4}, {63'd0, e.v});
            chk("z4", {63'd0, z4}, {63'd0, e.z});
            chk("busy_at_done4", {63'd0, busy4}, 64'd0);
        end
    endtask

    initial begin
        int   n, bc;
        logic seen;
        exp_t e;
        repeat (2) @(negedge clk);
        chk("rst_busy", {62'd0, busy4, busy32}, 64'd0);
        chk("rst_done", {62'd0, done4, done32}, 64'd0);
        chk("rst_res", {28'd0, res4, res32}, 64'd0);
        chk("rst_flags", {58'd0, co4, ov4, z4, co32, ov32, z32}, 64'd0);
        reset = 1'b0;

        go4(2'b00, 4'h7, 4'h1);
        wait4(4);
        go4(2'b01, 4'h3, 4'h3);
        wait4(4);
        go4(2'b01, 4'h8, 4'h1);
        wait4(4);

        // 32-bit wrap with busy-length count
        @(negedge clk);
        op32 = 2'b00; a32 = 32'hFFFF_FFFF; b32 = 32'h1; start32 = 1'b1;
        q32.push_back(model(32, 2'b00, 64'hFFFF_FFFF, 64'h1));
        @(negedge clk);
        start32 = 1'b0;
        n = 0; bc = 0;
        while (!done32 && n < 60) begin
            if (busy32) bc++;
            @(negedge clk);
            n++;
        end
        chk("timeout32", {63'd0, done32}, 64'd1);
        chk("busy32_len", bc, 32);
        if (done32 && q32.size() > 0) begin
            e = q32.pop_front();
            chk("res32", {32'd0, res32}, e.r);
            chk("flags32", {61'd0, co32, ov32, z32}, {61'd0, e.c, e.v, e.z});
        end

        // start during RUN is ignored
        go4(2'b00, 4'h1, 4'h2);
        op4 = 2'b01; a4 = 4'h5; b4 = 4'h5; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        wait4(3);

        // back-to-back accept in the done cycle
        go4(2'b00, 4'h3, 4'h4);
        wait4(4);
        op4 = 2'b01; a4 = 4'h2; b4 = 4'h5; start4 = 1'b1;
        q4.push_back(model(4, 2'b01, 64'h2, 64'h5));
        @(negedge clk);
        chk("b2b_busy", {63'd0, busy4}, 64'd1);
        start4 = 1'b0;
        wait4(4);

        // asynchronous reset in the second RUN cycle
        go4(2'b00, 4'h9, 4'h9);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("arst_res", {60'd0, res4}, 64'd0);
        chk("arst_ctl", {62'd0, busy4, done4}, 64'd0);
        chk("arst_flags", {61'd0, co4, ov4, z4}, 64'd0);
        q4.delete();
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= done4;
        end
        chk("no_done_after_abort", {63'd0, seen}, 64'd0);
        go4(2'b00, 4'h2, 4'h2);
        wait4(4);

        // op 2'b10: SLT when enabled, ADD otherwise
`ifdef SERIAL_SLT_EN
        go4(2'b10, 4'hE, 4'h1);
        wait4(4);
        go4(2'b10, 4'h7, 4'h8);
        wait4(4);
`else
        go4(2'b10, 4'h2, 4'h3);
        wait4(4);
`endif

        for (int i = 0; i < 6; i++) begin
            go4(2'($urandom_range(3)), 4'($urandom), 4'($urandom));
            wait4(4);
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
